rx_frame_loader: RTL and testbench

- Downstream consumer of the PC receive path's 32-bit word FIFO.
- Once armed by a frame-start pulse, drains FIFO words one at a time and writes them to a frame buffer at incrementing addresses 0..WORDS_PER_FRAME-1, honouring a memory-ready backpressure signal.
- Signals completion with a one-cycle pulse.
- Sits between the PC receive FIFO and the frame/line buffer inside the data manager.

---
 rtl/rx_frame_loader_if.sv | 46 ++++
 rtl/rx_frame_loader.sv | 163 ++++++++++++++++
 tb/tb_rx_frame_loader.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_loader_if.sv
// -----------------------------------------------------------------------------
// rx_frame_loader_if
//
// Bundles every signal of rx_frame_loader except clock and reset: frame
// control, the receive-FIFO read side, the frame-buffer write side and the
// status outputs.
//
// Parameters:
//   ADDR_WIDTH - frame-buffer address width; must match the loader instance.
//
// Modports:
//   master - the loader: samples i_* and drives o_*.
//   slave  - the environment (FIFO, frame buffer, control): drives i_* and
//            samples o_*.
// -----------------------------------------------------------------------------
interface rx_frame_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  i_frame_start;
    logic                  i_fifo_empty;
    logic [31:0]           i_fifo_word;
    logic                  o_fifo_read_cmd;
    logic                  o_mem_wr_en;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [31:0]           o_mem_wr_data;
    logic                  i_mem_ready;
    logic                  o_busy;
    logic [ADDR_WIDTH:0]   o_word_count;
    logic                  o_frame_done;
    logic                  o_frame_aborted;
    logic [31:0]           o_frame_checksum;

    modport master (
        input  i_frame_start, i_fifo_empty, i_fifo_word, i_mem_ready,
        output o_fifo_read_cmd, o_mem_wr_en, o_mem_addr, o_mem_wr_data,
               o_busy, o_word_count, o_frame_done, o_frame_aborted,
               o_frame_checksum
    );

    modport slave (
        output i_frame_start, i_fifo_empty, i_fifo_word, i_mem_ready,
        input  o_fifo_read_cmd, o_mem_wr_en, o_mem_addr, o_mem_wr_data,
               o_busy, o_word_count, o_frame_done, o_frame_aborted,
               o_frame_checksum
    );
endinterface

// File: rtl/rx_frame_loader.sv
// -----------------------------------------------------------------------------
// rx_frame_loader
//
// Drains a frame of 32-bit words from the PC receive FIFO (non-show-ahead,
// one clock of read latency) into the frame buffer at addresses
// 0..WORDS_PER_FRAME-1, one word at a time, honouring frame-buffer
// backpressure. A frame-start pulse arms the load; a pulse arriving while a
// load is in progress aborts it and restarts from address 0.
//
// Ports:
//   i_clock    - system clock, rising edge
//   i_reset_n  - asynchronous active-low reset
//   bus        - rx_frame_loader_if.master:
//                  i_frame_start     arm / restart pulse
//                  i_fifo_empty      FIFO empty flag (sampled in FETCH only)
//                  i_fifo_word       FIFO data, valid one clock after a read
//                  o_fifo_read_cmd   one-cycle FIFO read request
//                  o_mem_wr_en       frame-buffer write request
//                  o_mem_addr        write address
//                  o_mem_wr_data     write data
//                  i_mem_ready       write accepted when high with wr_en
//                  o_busy            high whenever not IDLE
//                  o_word_count      words accepted in the current frame
//                  o_frame_done      one-cycle pulse after the last word
//                  o_frame_aborted   one-cycle pulse on mid-load restart
//                  o_frame_checksum  sum of accepted words (optional)
//
// Build option:
//   RX_FRAME_LOADER_CHECKSUM_EN - when defined, a 32-bit wrapping accumulator
//   sums every accepted word; otherwise o_frame_checksum is tied to zero.
// -----------------------------------------------------------------------------
module rx_frame_loader #(
    parameter int ADDR_WIDTH      = 10,
    parameter int WORDS_PER_FRAME = 768
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    rx_frame_loader_if.master  bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS_PER_FRAME - 1);

    state_t state;

    // A start pulse in FETCH/WAIT/WRITE abandons the current frame. DONE is
    // excluded: the frame there is already complete, so it is a plain restart.
    logic abort;
    assign abort = bus.i_frame_start && (state != ST_IDLE) && (state != ST_DONE);

    // NOTE: every state bit and registered output is assigned with <= so all
    // of them update together from the values sampled at the same edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state               <= ST_IDLE;
            bus.o_fifo_read_cmd <= 1'b0;
            bus.o_mem_wr_en     <= 1'b0;
            bus.o_mem_addr      <= '0;
            bus.o_mem_wr_data   <= '0;
            bus.o_busy          <= 1'b0;
            bus.o_word_count    <= '0;
            bus.o_frame_done    <= 1'b0;
            bus.o_frame_aborted <= 1'b0;
        end else begin
            // Pulse outputs fall back to zero unless a branch re-asserts them.
            bus.o_fifo_read_cmd <= 1'b0;
            bus.o_frame_done    <= 1'b0;
            bus.o_frame_aborted <= 1'b0;

            if (abort) begin
                // Any word in flight or waiting for acceptance is dropped; a
                // transfer completing this same edge still counts as written
                // by the frame buffer, but the count restarts regardless.
                state               <= ST_FETCH;
                bus.o_mem_wr_en     <= 1'b0;
                bus.o_mem_addr      <= '0;
                bus.o_word_count    <= '0;
                bus.o_busy          <= 1'b1;
                bus.o_frame_aborted <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (bus.i_frame_start) begin
                            state            <= ST_FETCH;
                            bus.o_mem_addr   <= '0;
                            bus.o_word_count <= '0;
                            bus.o_busy       <= 1'b1;
                        end
                    end

                    ST_FETCH: begin
                        if (!bus.i_fifo_empty) begin
                            state               <= ST_WAIT;
                            bus.o_fifo_read_cmd <= 1'b1;
                        end
                    end

                    ST_WAIT: begin
                        // Requested word is presented by the FIFO by the end
                        // of this cycle.
                        state             <= ST_WRITE;
                        bus.o_mem_wr_data <= bus.i_fifo_word;
                        bus.o_mem_wr_en   <= 1'b1;
                    end

                    ST_WRITE: begin
                        if (bus.i_mem_ready) begin
                            bus.o_mem_wr_en  <= 1'b0;
                            bus.o_word_count <= bus.o_word_count + (ADDR_WIDTH + 1)'(1);
                            if (bus.o_mem_addr == LAST_ADDR) begin
                                state            <= ST_DONE;
                                bus.o_frame_done <= 1'b1;
                            end else begin
                                state          <= ST_FETCH;
                                bus.o_mem_addr <= bus.o_mem_addr + ADDR_WIDTH'(1);
                            end
                        end
                    end

                    ST_DONE: begin
                        if (bus.i_frame_start) begin
                            state            <= ST_FETCH;
                            bus.o_mem_addr   <= '0;
                            bus.o_word_count <= '0;
                        end else begin
                            state      <= ST_IDLE;
                            bus.o_busy <= 1'b0;
                        end
                    end

                    default: begin
                        state           <= ST_IDLE;
                        bus.o_mem_wr_en <= 1'b0;
                        bus.o_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RX_FRAME_LOADER_CHECKSUM_EN
    // Every start pulse (arm, abort or restart from DONE) clears the sum, and
    // the clear wins over a transfer landing on the same edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus.o_frame_checksum <= '0;
        end else if (bus.i_frame_start) begin
            bus.o_frame_checksum <= '0;
        end else if ((state == ST_WRITE) && bus.i_mem_ready) begin
            bus.o_frame_checksum <= bus.o_frame_checksum + bus.o_mem_wr_data;
        end
    end
`else
    assign bus.o_frame_checksum = '0;
`endif

endmodule

// File: tb/tb_rx_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_loader
//
// Directed bench for rx_frame_loader with WORDS_PER_FRAME = 4. A queue models
// the non-show-ahead FIFO: a read request seen high in a cycle pops the head
// onto i_fifo_word before the edge that ends that cycle. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_rx_frame_loader;
    localparam int AW  = 10;
    localparam int WPF = 4;

`ifdef RX_FRAME_LOADER_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rx_frame_loader_if #(.ADDR_WIDTH(AW)) bus ();

    rx_frame_loader #(
        .ADDR_WIDTH      (AW),
        .WORDS_PER_FRAME (WPF)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    wr_t         wr_log[$];
    logic [31:0] fifo_q[$];
    bit          fifo_block;
    bit          prev_rd;
    int          cyc, done_cyc;
    int          n_reads, n_overlap, n_back2back;
    int          n_vec, n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic update_empty();
        bus.i_fifo_empty = fifo_block || (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        update_empty();
    endtask

    // Logs what the coming rising edge does with the current outputs and the
    // inputs already applied, advances to the next falling edge, then serves
    // any FIFO read requested in the new cycle.
    task automatic step();
        wr_t w;
        if (bus.o_mem_wr_en && bus.i_mem_ready) begin
            w.addr = bus.o_mem_addr;
            w.data = bus.o_mem_wr_data;
            w.cyc  = cyc;
            wr_log.push_back(w);
        end
        if (bus.o_fifo_read_cmd) n_reads++;
        if (bus.o_fifo_read_cmd && prev_rd) n_back2back++;
        if (bus.o_fifo_read_cmd && bus.o_mem_wr_en) n_overlap++;
        prev_rd = bus.o_fifo_read_cmd;
        @(negedge clk);
        cyc++;
        if (bus.o_fifo_read_cmd) begin
            if (fifo_q.size() != 0) bus.i_fifo_word = fifo_q.pop_front();
            else                    bus.i_fifo_word = 32'hDEAD_BEEF;
        end
        update_empty();
        if (bus.o_frame_done) done_cyc = cyc;
    endtask

    task automatic start_frame();
        bus.i_frame_start = 1'b1;
        step();
        bus.i_frame_start = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (bus.o_frame_done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t1_words [4];
        int  c0, r0, held, activity, n_pre, n_a2;
        bit  seen;

        t1_words[0] = 32'h1111_1111;
        t1_words[1] = 32'h2222_2222;
        t1_words[2] = 32'h3333_3333;
        t1_words[3] = 32'h4444_4444;

        bus.i_frame_start = 1'b0;
        bus.i_fifo_empty  = 1'b1;
        bus.i_fifo_word   = '0;
        bus.i_mem_ready   = 1'b1;
        fifo_block        = 1'b0;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        step();
        step();
        check("rst_flags", 32'({bus.o_busy, bus.o_fifo_read_cmd, bus.o_mem_wr_en,
                                bus.o_frame_done, bus.o_frame_aborted}), 32'd0);
        check("rst_addr",     32'(bus.o_mem_addr), 32'd0);
        check("rst_count",    32'(bus.o_word_count), 32'd0);
        check("rst_data",     bus.o_mem_wr_data, 32'd0);
        check("rst_checksum", bus.o_frame_checksum, 32'd0);
        rst_n = 1'b1;
        step();
        step();

        // ---------------- basic 4-word frame ----------------
        for (int i = 0; i < 4; i++) push(t1_words[i]);
        wr_log.delete();
        r0 = n_reads;
        c0 = cyc;
        start_frame();
        run_to_done("t1", 40);
        check("t1_nwrites", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < wr_log.size() && i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), 32'(wr_log[i].addr), 32'(i));
            check($sformatf("t1_data%0d", i), wr_log[i].data, t1_words[i]);
            check($sformatf("t1_cyc%0d", i),  32'(wr_log[i].cyc), 32'(c0 + 3 + 3 * i));
        end
        check("t1_done_cyc",  32'(done_cyc), 32'(c0 + 13));
        check("t1_count",     32'(bus.o_word_count), 32'd4);
        check("t1_checksum",  bus.o_frame_checksum, CKS_EN ? 32'hAAAA_AAAA : 32'd0);
        check("t1_reads",     32'(n_reads - r0), 32'd4);
        step();
        check("t1_done_pulse", 32'(bus.o_frame_done), 32'd0);
        check("t1_idle_busy",  32'(bus.o_busy), 32'd0);
        check("t1_count_held", 32'(bus.o_word_count), 32'd4);

        // ---------------- FIFO empty for 20 cycles ----------------
        fifo_block = 1'b1;
        push(32'h5555_5555);
        push(32'h6666_6666);
        push(32'h7777_7777);
        push(32'h8888_8888);
        wr_log.delete();
        start_frame();
        activity = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.o_fifo_read_cmd || bus.o_mem_wr_en) activity++;
        end
        check("t2_no_activity", 32'(activity), 32'd0);
        check("t2_busy",        32'(bus.o_busy), 32'd1);
        fifo_block = 1'b0;
        update_empty();
        step();
        check("t2_read_next", 32'(bus.o_fifo_read_cmd), 32'd1);

        // ---------------- backpressure on word 2 ----------------
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (wr_log.size() >= 1) seen = 1'b1;
        end
        check("t3_word0_written", 32'(seen), 32'd1);
        bus.i_mem_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.o_mem_wr_en) seen = 1'b1;
            else step();
        end
        check("t3_reach_write", 32'(seen), 32'd1);
        r0   = n_reads;
        held = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.o_mem_wr_en && bus.o_mem_addr == AW'(1) &&
                bus.o_mem_wr_data == 32'h6666_6666) held++;
            step();
        end
        if (bus.o_mem_wr_en && bus.o_mem_addr == AW'(1) &&
            bus.o_mem_wr_data == 32'h6666_6666) held++;
        bus.i_mem_ready = 1'b1;
        step();
        check("t3_held_cycles", 32'(held), 32'd6);
        check("t3_no_extra_read", 32'(n_reads - r0), 32'd0);
        check("t3_nwrites_after", 32'(wr_log.size()), 32'd2);
        run_to_done("t3", 40);
        check("t3_nwrites", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() >= 2) check("t3_word1_data", wr_log[1].data, 32'h6666_6666);
        check("t3_count", 32'(bus.o_word_count), 32'd4);
        step();

        // ---------------- abort while writing addr 2 ----------------
        push(32'hA000_0000);
        push(32'hA100_0001);
        push(32'hA200_0002);
        push(32'hB000_0000);
        push(32'hB100_0001);
        push(32'hB200_0002);
        push(32'hB300_0003);
        wr_log.delete();
        start_frame();
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus.o_mem_wr_en && bus.o_mem_addr == AW'(2)) seen = 1'b1;
            else step();
        end
        check("t4_reach_addr2", 32'(seen), 32'd1);
        bus.i_mem_ready   = 1'b0;
        bus.i_frame_start = 1'b1;
        step();
        bus.i_frame_start = 1'b0;
        bus.i_mem_ready   = 1'b1;
        n_pre = wr_log.size();
        check("t4_aborted",   32'(bus.o_frame_aborted), 32'd1);
        check("t4_wr_en_off", 32'(bus.o_mem_wr_en), 32'd0);
        check("t4_count",     32'(bus.o_word_count), 32'd0);
        check("t4_addr",      32'(bus.o_mem_addr), 32'd0);
        check("t4_busy",      32'(bus.o_busy), 32'd1);
        check("t4_pre_writes", 32'(n_pre), 32'd2);
        step();
        check("t4_abort_pulse", 32'(bus.o_frame_aborted), 32'd0);
        run_to_done("t4", 60);
        check("t4_nwrites", 32'(wr_log.size()), 32'd6);
        if (wr_log.size() >= 3) begin
            check("t4_restart_addr", 32'(wr_log[2].addr), 32'd0);
            check("t4_restart_data", wr_log[2].data, 32'hB000_0000);
        end
        n_a2 = 0;
        foreach (wr_log[i]) if (wr_log[i].data == 32'hA200_0002) n_a2++;
        check("t4_no_a2_write", 32'(n_a2), 32'd0);
        check("t4_checksum", bus.o_frame_checksum, CKS_EN ? 32'hC600_0006 : 32'd0);
        step();

        // ---------------- reset during WAIT ----------------
        push(32'hC000_0000);
        push(32'hC100_0001);
        push(32'hC200_0002);
        push(32'hC300_0003);
        start_frame();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.o_fifo_read_cmd) seen = 1'b1;
            else step();
        end
        check("t5_reach_wait", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_flags", 32'({bus.o_busy, bus.o_fifo_read_cmd, bus.o_mem_wr_en,
                               bus.o_frame_done, bus.o_frame_aborted}), 32'd0);
        check("t5_data",     bus.o_mem_wr_data, 32'd0);
        check("t5_addr_cnt", 32'({bus.o_mem_addr, bus.o_word_count}), 32'd0);
        check("t5_checksum", bus.o_frame_checksum, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        r0 = n_reads;
        for (int i = 0; i < 10; i++) step();
        check("t5_no_reads", 32'(n_reads - r0), 32'd0);
        check("t5_idle",     32'(bus.o_busy), 32'd0);
        fifo_q.delete();
        update_empty();

        // ---------------- checksum wrap, restart from DONE ----------------
        push(32'hFFFF_FFFF);
        push(32'h0000_0002);
        push(32'h0000_0000);
        push(32'h0000_0000);
        start_frame();
        run_to_done("t6", 40);
        check("t6_checksum", bus.o_frame_checksum, CKS_EN ? 32'h0000_0001 : 32'd0);
        check("t6_count",    32'(bus.o_word_count), 32'd4);
        bus.i_frame_start = 1'b1;
        step();
        bus.i_frame_start = 1'b0;
        check("t6_no_abort",     32'(bus.o_frame_aborted), 32'd0);
        check("t6_restart_busy", 32'(bus.o_busy), 32'd1);
        check("t6_restart_cnt",  32'(bus.o_word_count), 32'd0);
        check("t6_restart_cks",  bus.o_frame_checksum, 32'd0);
        push(32'h0000_0010);
        push(32'h0000_0020);
        push(32'h0000_0030);
        push(32'h0000_0040);
        run_to_done("t6r", 40);
        check("t6r_count",    32'(bus.o_word_count), 32'd4);
        check("t6r_checksum", bus.o_frame_checksum, CKS_EN ? 32'h0000_00A0 : 32'd0);
        step();

        // ---------------- global handshake properties ----------------
        check("no_rd_wr_overlap",   32'(n_overlap), 32'd0);
        check("no_back2back_reads", 32'(n_back2back), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
